// File: rtl/gb_apu_pulse_gen_if.sv
// Register/strobe bundle between frame sequencer, register file and one pulse channel.
// The master drives configuration and strobes; the slave is the channel itself.
interface gb_apu_pulse_gen_if #(
    parameter int FREQ_W  = 11,
    parameter int LEN_W   = 6,
    parameter int VOL_W   = 4,
    parameter int ENV_W   = 3,
    parameter int SWP_T_W = 3,
    parameter int SWP_S_W = 3
);
    logic               clk_length_ctr;
    logic               clk_vol_env;
    logic               clk_sweep;
    logic [SWP_T_W-1:0] sweep_time;
    logic               sweep_decreasing;
    logic [SWP_S_W-1:0] num_sweep_shifts;
    logic [1:0]         wave_duty;
    logic [LEN_W-1:0]   length;
    logic [VOL_W-1:0]   initial_volume;
    logic               envelope_increasing;
    logic [ENV_W-1:0]   num_envelope_sweeps;
    logic               start;
    logic               single;
    logic [FREQ_W-1:0]  frequency;
    logic [VOL_W-1:0]   level;
    logic               enable;

    modport master (
        output clk_length_ctr, clk_vol_env, clk_sweep,
        output sweep_time, sweep_decreasing, num_sweep_shifts,
        output wave_duty, length, initial_volume,
        output envelope_increasing, num_envelope_sweeps,
        output start, single, frequency,
        input  level, enable
    );

    modport slave (
        input  clk_length_ctr, clk_vol_env, clk_sweep,
        input  sweep_time, sweep_decreasing, num_sweep_shifts,
        input  wave_duty, length, initial_volume,
        input  envelope_increasing, num_envelope_sweeps,
        input  start, single, frequency,
        output level, enable
    );
endinterface

// File: rtl/gb_apu_pulse_gen.sv
// Pulse channel: 8-step duty, length counter, volume envelope.
// Define GB_APU_PULSE_SWEEP_EN to build in the frequency sweep unit.
module gb_apu_pulse_gen #(
    parameter int FREQ_W  = 11,
    parameter int LEN_W   = 6,
    parameter int VOL_W   = 4,
    parameter int ENV_W   = 3,
    parameter int SWP_T_W = 3,
    parameter int SWP_S_W = 3
) (
    input logic               clk_i,
    input logic               reset_i,
    gb_apu_pulse_gen_if.slave bus
);
    localparam logic [FREQ_W-1:0] FMAX  = '1;
    localparam logic [VOL_W-1:0]  VMAX  = '1;
    localparam logic [LEN_W:0]    LFULL = {1'b1, {LEN_W{1'b0}}};

    logic              enable_q, enable_d;
    logic [VOL_W-1:0]  level_q, level_d;
    logic [2:0]        duty_q, duty_d;
    logic [FREQ_W-1:0] timer_q, timer_d;
    logic [LEN_W:0]    len_q, len_d;
    logic [VOL_W-1:0]  vol_q, vol_d;
    logic [ENV_W-1:0]  env_q, env_d;
    logic [FREQ_W-1:0] reload;
    logic [7:0]        pattern;
    logic              dac_off;

`ifdef GB_APU_PULSE_SWEEP_EN
    localparam logic [SWP_T_W:0] SFULL = {1'b1, {SWP_T_W{1'b0}}};
    logic [FREQ_W-1:0] shadow_q, shadow_d;
    logic [SWP_T_W:0]  swt_q, swt_d, swt_load;
    logic [FREQ_W:0]   trig_sum, swp_step, swp_new;

    assign swt_load = (bus.sweep_time == '0) ? SFULL
                                             : {1'b0, bus.sweep_time};
    assign trig_sum = {1'b0, bus.frequency}
                    + {1'b0, bus.frequency >> bus.num_sweep_shifts};
    assign swp_step = {1'b0, shadow_q >> bus.num_sweep_shifts};
    assign swp_new  = bus.sweep_decreasing ? {1'b0, shadow_q} - swp_step
                                           : {1'b0, shadow_q} + swp_step;
    assign reload   = shadow_q;
`else
    logic unused_sweep;
    assign unused_sweep = ^{bus.clk_sweep, bus.sweep_time,
                            bus.sweep_decreasing, bus.num_sweep_shifts};
    assign reload = bus.frequency;
`endif

    assign dac_off = (bus.initial_volume == '0) && !bus.envelope_increasing;

    always_comb begin
        pattern = 8'b0000_0001;
        case (bus.wave_duty)
            2'b00: pattern = 8'b0000_0001;
            2'b01: pattern = 8'b1000_0001;
            2'b10: pattern = 8'b1000_0111;
            2'b11: pattern = 8'b0111_1110;
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        duty_d   = duty_q;
        timer_d  = timer_q;
        len_d    = len_q;
        vol_d    = vol_q;
        env_d    = env_q;
`ifdef GB_APU_PULSE_SWEEP_EN
        shadow_d = shadow_q;
        swt_d    = swt_q;
`endif
        level_d = (enable_q && pattern[duty_q]) ? vol_q : '0;
        // Trigger wins outright; strobes in the same cycle are dropped.
        if (bus.start) begin
            enable_d = !dac_off;
            len_d    = LFULL - {1'b0, bus.length};
            timer_d  = bus.frequency;
            vol_d    = bus.initial_volume;
            env_d    = bus.num_envelope_sweeps;
`ifdef GB_APU_PULSE_SWEEP_EN
            shadow_d = bus.frequency;
            swt_d    = swt_load;
            if (bus.num_sweep_shifts != '0 && !bus.sweep_decreasing &&
                trig_sum > {1'b0, FMAX})
                enable_d = 1'b0;
`endif
        end else begin
            if (timer_q == FMAX) begin
                timer_d = reload;
                duty_d  = duty_q + 3'd1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            if (bus.clk_length_ctr && bus.single && len_q != '0) begin
                len_d = len_q - 1'b1;
                if (len_q == (LEN_W+1)'(1))
                    enable_d = 1'b0;
            end
            if (bus.clk_vol_env && bus.num_envelope_sweeps != '0) begin
                if (env_q <= ENV_W'(1)) begin
                    env_d = bus.num_envelope_sweeps;
                    if (bus.envelope_increasing && vol_q != VMAX)
                        vol_d = vol_q + 1'b1;
                    else if (!bus.envelope_increasing && vol_q != '0)
                        vol_d = vol_q - 1'b1;
                end else begin
                    env_d = env_q - 1'b1;
                end
            end
`ifdef GB_APU_PULSE_SWEEP_EN
            if (bus.clk_sweep) begin
                if (swt_q <= (SWP_T_W+1)'(1)) begin
                    swt_d = swt_load;
                    if (bus.sweep_time != '0) begin
                        if (swp_new > {1'b0, FMAX})
                            enable_d = 1'b0;
                        else if (bus.num_sweep_shifts != '0)
                            shadow_d = swp_new[FREQ_W-1:0];
                    end
                end else begin
                    swt_d = swt_q - 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            enable_q <= 1'b0;
            level_q  <= '0;
            duty_q   <= '0;
            timer_q  <= '0;
            len_q    <= '0;
            vol_q    <= '0;
            env_q    <= '0;
`ifdef GB_APU_PULSE_SWEEP_EN
            shadow_q <= '0;
            swt_q    <= '0;
`endif
        end else begin
            enable_q <= enable_d;
            level_q  <= level_d;
            duty_q   <= duty_d;
            timer_q  <= timer_d;
            len_q    <= len_d;
            vol_q    <= vol_d;
            env_q    <= env_d;
`ifdef GB_APU_PULSE_SWEEP_EN
            shadow_q <= shadow_d;
            swt_q    <= swt_d;
`endif
        end
    end

    assign bus.level  = level_q;
    assign bus.enable = enable_q;
endmodule
